// File: rtl/tea_search_pkg.sv
// -----------------------------------------------------------------------------
// tea_search_pkg
// Shared definitions for the TEA key-search sequencer and the TEA pipeline:
//   - state_t        : sequencer states
//   - PIPE_DEPTH_DEF : default number of registered TEA round stages
//   - PDF_MATCH_VAL / PDF_MATCH_MASK : PDF header pattern and compare mask
//   - TEA_DELTA / tea_sum() : per-stage decryption sum constants
//   - KEY_PFX_LC / KEY_PFX_UC : lowercase / uppercase key prefixes
// -----------------------------------------------------------------------------
package tea_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int          PIPE_DEPTH_DEF = 32;
    localparam int          IDX_W_DEF      = 30;

    // "%PDF-1." followed by a don't-care byte
    localparam logic [63:0] PDF_MATCH_VAL  = 64'h255044462D312E00;
    localparam logic [63:0] PDF_MATCH_MASK = 64'hFFFFFFFFFFFFFF00;

    localparam logic [79:0] KEY_PFX_LC     = 80'h48756c6b206973207468;
    localparam logic [79:0] KEY_PFX_UC     = 80'h48554c4b204953205448;

    localparam logic [31:0] TEA_DELTA      = 32'h9E3779B9;

    // Decryption runs the rounds backwards: stage 0 uses sum = 32*delta,
    // stage 31 uses sum = 1*delta (arithmetic is modulo 2^32).
    function automatic logic [31:0] tea_sum(input int stage);
        logic [31:0] rounds;
        rounds = 32'(32 - stage);
        return 32'(TEA_DELTA * rounds);
    endfunction

endpackage

// File: rtl/tea_cand_counter.sv
// -----------------------------------------------------------------------------
// tea_cand_counter
// Candidate index/mode counter. idx counts 0..2^IDX_W-1 with mode=0, then wraps
// and counts again with mode=1. last_o flags the final candidate.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   ena_i          : global advance enable (all updates gated)
//   clr_i          : restart at idx=0, mode=0
//   inc_i          : advance to the next candidate
//   idx_o, mode_o  : current candidate
//   last_o         : current candidate is idx=all-ones, mode=1
// -----------------------------------------------------------------------------
import tea_search_pkg::*;

module tea_cand_counter #(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             mode_o,
    output logic             last_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;

    assign last_o = (&idx_q) & mode_q;

    always_comb begin
        idx_d  = idx_q;
        mode_d = mode_q;
        if (clr_i) begin
            idx_d  = '0;
            mode_d = 1'b0;
        end else if (inc_i && !last_o) begin
            if (&idx_q) begin
                idx_d  = '0;
                mode_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            mode_q <= 1'b0;
        end else if (ena_i) begin
            idx_q  <= idx_d;
            mode_q <= mode_d;
        end
    end

    assign idx_o  = idx_q;
    assign mode_o = mode_q;

endmodule

// File: rtl/tea_search_ctrl.sv
// -----------------------------------------------------------------------------
// tea_search_ctrl
// Sequencer for the pipelined TEA decryptor used by the key-search instruction.
// Latches the ciphertext on start, issues every {mode, idx} candidate, tracks
// in-flight candidates with a valid shift register and compares each decrypted
// block against the PDF header. Reports {found, tag} or exhaustion via
// result/rdy.
//
// Optional: define TEA_SEARCH_PERF_EN to add perf_cycles, a saturating count
// of ena cycles spent in RUN or DRAIN (cleared on accepted start).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ena               : global advance enable
//   start, dataA/B    : request and ciphertext words (accepted in IDLE only)
//   cipher            : latched ciphertext to pipeline stage 0
//   cand_idx/mode/valid : candidate issued to the key decoders
//   pipe_adv          : pipeline stage enable
//   pipe_plain/tag    : pipeline output block and its {mode, idx} tag
//   result, rdy       : {found, 0.., tag} and one-cycle completion pulse
//   busy              : search in progress (RUN or DRAIN)
//   perf_cycles       : (TEA_SEARCH_PERF_EN only) active cycle count
//
// State     | meaning
// IDLE      | waiting for start; result holds last outcome
// RUN       | issuing one candidate per ena cycle
// DRAIN     | all candidates issued, waiting for the pipeline to empty
// -----------------------------------------------------------------------------
import tea_search_pkg::*;

module tea_search_ctrl #(
    parameter int          PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int          IDX_W      = IDX_W_DEF,
    parameter logic [63:0] MATCH_VAL  = PDF_MATCH_VAL,
    parameter logic [63:0] MATCH_MASK = PDF_MATCH_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [31:0]      dataA,
    input  logic [31:0]      dataB,
    output logic [63:0]      cipher,
    output logic [IDX_W-1:0] cand_idx,
    output logic             cand_mode,
    output logic             cand_valid,
    output logic             pipe_adv,
    input  logic [63:0]      pipe_plain,
    input  logic [IDX_W:0]   pipe_tag,
    output logic [31:0]      result,
    output logic             rdy,
    output logic             busy
`ifdef TEA_SEARCH_PERF_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    state_t                state_q, state_d;
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [63:0]           cipher_q, cipher_d;
    logic [31:0]           result_q, result_d;
    logic                  rdy_q, rdy_d;

    logic                  accept;
    logic                  cnt_inc;
    logic                  cnt_last;
    logic                  out_valid;
    logic                  match;
    logic [31:0]           found_word;

    tea_cand_counter #(.IDX_W(IDX_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .ena_i  (ena),
        .clr_i  (accept),
        .inc_i  (cnt_inc),
        .idx_o  (cand_idx),
        .mode_o (cand_mode),
        .last_o (cnt_last)
    );

    assign cand_valid = (state_q == RUN);
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign out_valid  = vld_q[PIPE_DEPTH-1];
    assign match      = out_valid && (((pipe_plain ^ MATCH_VAL) & MATCH_MASK) == 64'd0);

    // found flag sits in bit 31, tag in the low bits, zeros in between
    always_comb begin
        found_word            = '0;
        found_word[IDX_W:0]   = pipe_tag;
        found_word[31]        = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        vld_d    = {vld_q[PIPE_DEPTH-2:0], cand_valid};
        cipher_d = cipher_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        accept   = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    cipher_d = {dataA, dataB};
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                cnt_inc = 1'b1;
                if (match) begin
                    result_d = found_word;
                    rdy_d    = 1'b1;
                    vld_d    = '0;
                    state_d  = IDLE;
                end else if (cnt_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (match) begin
                    result_d = found_word;
                    rdy_d    = 1'b1;
                    vld_d    = '0;
                    state_d  = IDLE;
                end else if (vld_d == '0) begin
                    // last in-flight candidate leaves the pipe this cycle
                    result_d = '0;
                    rdy_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vld_q    <= '0;
            cipher_q <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            cipher_q <= cipher_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
        end
    end

    assign cipher   = cipher_q;
    assign result   = result_q;
    assign rdy      = rdy_q;
    assign pipe_adv = ena;

`ifdef TEA_SEARCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (ena) begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/tea_search_ctrl.md
Name: tea_search_ctrl

Overview:
- Sequencer for the 32-stage pipelined TEA decryptor used in the key-search custom instruction.
- On `start`, latches the 64-bit ciphertext. Issues one key-candidate index per enabled cycle, covering both key-prefix case variants (`mode`).
- Tracks in-flight candidates with a valid shift register and checks each decrypted block against the PDF header pattern.
- Reports the winning candidate tag, or exhaustion, to the CPU through `result`/`rdy`.

Parameters:
- PIPE_DEPTH, 32, number of registered TEA round stages between candidate issue and plaintext output.
- IDX_W, 30, candidate index width (six 5-bit characters).
- MATCH_VAL, 64'h255044462D312E00, expected plaintext ("%PDF-1." plus don't-care byte).
- MATCH_MASK, 64'hFFFFFFFFFFFFFF00, bits of MATCH_VAL that are compared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  global advance enable; when low, the controller and pipeline hold all state
- start  in  1  one-cycle request from the CPU; honoured only in IDLE
- dataA  in  32  ciphertext high word; sampled with start
- dataB  in  32  ciphertext low word; sampled with start
- cipher  out  64  latched ciphertext, drives pipeline stage 0 data
- cand_idx  out  IDX_W  candidate index to the character decoders
- cand_mode  out  1  key-prefix variant: 0 = lowercase, 1 = uppercase
- cand_valid  out  1  candidate on cand_idx/cand_mode is real
- pipe_adv  out  1  pipeline stage-register enable (= ena)
- pipe_plain  in  64  plaintext at pipeline output
- pipe_tag  in  IDX_W+1  {mode, idx} carried through pipeline alongside the data
- result  out  32  {found, pipe_tag}; zero-extended when IDX_W < 31
- rdy  out  1  one-cycle completion pulse
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset values: state=IDLE, cand_idx=0, cand_mode=0, cand_valid=0, valid shift register all 0, cipher=0, result=0, rdy=0, busy=0.
- All register updates are gated by ena, except rst. rst wins over ena.
- IDLE:
  - start=1 latches cipher={dataA,dataB} and clears idx/mode to 0.
  - Next state RUN. First candidate is valid in the following cycle.
- RUN:
  - cand_valid=1. Each ena cycle, idx increments.
  - At idx=all-ones with mode=0: idx wraps to 0 and mode becomes 1.
  - At idx=all-ones with mode=1: that candidate is the last. Next state DRAIN, cand_valid=0.
- Valid shift register (PIPE_DEPTH bits):
  - Shifts in cand_valid each ena cycle.
  - out_valid is its MSB.
  - A candidate issued in cycle t is checked at the ena cycle t+PIPE_DEPTH.
- Match: out_valid && ((pipe_plain ^ MATCH_VAL) & MATCH_MASK)==0.
  - Checked in RUN and DRAIN.
  - On match: result={1'b1, pipe_tag}, rdy=1 for one cycle, flush all valid bits, next state IDLE.
  - The match has priority over the RUN→DRAIN transition in the same cycle.
- DRAIN:
  - No issue.
  - When the valid register is all 0 and no match: result=32'h0, rdy pulse, next state IDLE.
- start in RUN/DRAIN is ignored. Only the first match is reported.
- result holds its value until the next accepted start, which clears it to 0.
- rst mid-search returns to IDLE immediately, with no rdy pulse.
- Exhaustive search, no match, ena always 1: rdy occurs exactly 2^(IDX_W+1)+PIPE_DEPTH+1 cycles after start.

Optional Feature:
- Macro: TEA_SEARCH_PERF_EN.
- Defined:
  - Adds output perf_cycles[31:0], which counts ena cycles spent in RUN or DRAIN.
  - Cleared on accepted start. Saturates at 32'hFFFFFFFF. Holds its value in IDLE.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package tea_search_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - PIPE_DEPTH default
  - PDF MATCH_VAL/MATCH_MASK
  - the 32 per-stage TEA sum constants, shared with the pipeline instantiation
  - key prefix constants 80'h48756c6b206973207468 and 80'h48554c4b204953205448
- Sub-module tea_cand_counter: idx/mode counter with wrap and last flag.

Test Plan (IDX_W=4, PIPE_DEPTH=4 unless stated):
- Reset then idle: rst=1 for 2 cycles, start=0 → rdy=0, busy=0, result=0, cand_valid=0.
- Forced match: model returns MATCH_VAL when tag=5'b1_0011; start with dataA=32'h11223344, dataB=32'h55667788 → cipher=64'h1122334455667788; rdy pulses with result=32'h00000013 | 32'h80000000 = 32'h80000013; no further rdy.
- Exhaustion: plaintext never matches → rdy at cycle 32+4+1=37 after start, result=0; mode seen 0 for idx 0..15, then 1 for idx 0..15.
- ena stall: ena=0 for 10 cycles mid-RUN → cand_idx, the valid register and the rdy timing shift by exactly 10 cycles.
- start while busy: second start at cycle 3 with new data → cipher unchanged, single rdy.
- Reset mid-DRAIN: rst at cycle 34 → IDLE the next cycle, no rdy, busy=0; a following start runs normally. With TEA_SEARCH_PERF_EN, perf_cycles=36 after exhaustion.
